// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit fed by the register file.
// One shift-add (multiply) or restoring-subtract (divide) step per clock.
// The result lands in hi/lo in a single final cycle, behind a start/busy/done handshake.
// Optional feature macro: MULDIV_SIGNED_EN. When it is defined, op 01 (MULT)
// and op 11 (DIV) are signed. When it is undefined, op[0] is ignored and
// every operation runs unsigned.
module mul_div_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             is_div_r;
  logic             dbz_pend_r;
  logic [WIDTH-1:0] a_raw_r;
  logic [WIDTH-1:0] opnd_r;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0] work_hi_r;  // partial product high half / partial remainder
  logic [WIDTH-1:0] work_lo_r;  // multiplier being shifted out / quotient being shifted in

  logic [WIDTH-1:0] mag_a_s;
  logic [WIDTH-1:0] mag_b_s;
  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH:0]   div_shift_s;
  logic             div_ge_s;
  logic [WIDTH-1:0] div_diff_s;
  logic [WIDTH-1:0] next_hi_s;
  logic [WIDTH-1:0] next_lo_s;
  logic [WIDTH-1:0] res_hi_s;
  logic [WIDTH-1:0] res_lo_s;

`ifdef MULDIV_SIGNED_EN
  logic             sign_a_s;
  logic             sign_b_s;
  logic             neg_main_r;  // negate product, or negate quotient
  logic             neg_rem_r;   // remainder follows the dividend sign
  logic [2*WIDTH-1:0] prod_s;

  // Two's-complement negation of one operand-width word.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return (~x) + WIDTH'(1);
  endfunction

  // Two's-complement negation of a full double-width product.
  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return (~x) + (2*WIDTH)'(1);
  endfunction

  // Split signed operands into sign bits and unsigned magnitudes.
  always_comb begin
    sign_a_s = op[0] & a[WIDTH-1];
    sign_b_s = op[0] & b[WIDTH-1];
    mag_a_s  = sign_a_s ? neg_w(a) : a;
    mag_b_s  = sign_b_s ? neg_w(b) : b;
  end
`else
  logic unused_op_s;

  // Without signed support the operands are already their own magnitudes.
  always_comb begin
    mag_a_s = a;
    mag_b_s = b;
  end

  assign unused_op_s = op[0];
`endif

  // One iteration step of either the shift-add multiply or the restoring divide.
  always_comb begin
    mul_sum_s   = {1'b0, work_hi_r} + (work_lo_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    div_shift_s = {work_hi_r, work_lo_r[WIDTH-1]};
    div_ge_s    = (div_shift_s >= {1'b0, opnd_r});
    div_diff_s  = div_shift_s[WIDTH-1:0] - opnd_r;
    if (is_div_r) begin
      if (div_ge_s) begin
        next_hi_s = div_diff_s;
        next_lo_s = {work_lo_r[WIDTH-2:0], 1'b1};
      end else begin
        next_hi_s = div_shift_s[WIDTH-1:0];
        next_lo_s = {work_lo_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      next_hi_s = mul_sum_s[WIDTH:1];
      next_lo_s = {mul_sum_s[0], work_lo_r[WIDTH-1:1]};
    end
  end

  // Final result: sign correction and the divide-by-zero override.
  always_comb begin
`ifdef MULDIV_SIGNED_EN
    prod_s = {work_hi_r, work_lo_r};
`endif
    res_hi_s = work_hi_r;
    res_lo_s = work_lo_r;
    if (is_div_r) begin
      if (dbz_pend_r) begin
        res_hi_s = a_raw_r;
        res_lo_s = {WIDTH{1'b1}};
      end else begin
`ifdef MULDIV_SIGNED_EN
        res_lo_s = neg_main_r ? neg_w(work_lo_r) : work_lo_r;
        res_hi_s = neg_rem_r ? neg_w(work_hi_r) : work_hi_r;
`else
        res_lo_s = work_lo_r;
        res_hi_s = work_hi_r;
`endif
      end
    end else begin
`ifdef MULDIV_SIGNED_EN
      if (neg_main_r) begin
        prod_s = neg_2w({work_hi_r, work_lo_r});
      end else begin
        prod_s = {work_hi_r, work_lo_r};
      end
      res_hi_s = prod_s[2*WIDTH-1:WIDTH];
      res_lo_s = prod_s[WIDTH-1:0];
`else
      res_hi_s = work_hi_r;
      res_lo_s = work_lo_r;
`endif
    end
  end

  // Control FSM: IDLE accepts and latches, RUN iterates, FIN publishes hi/lo.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      is_div_r    <= 1'b0;
      dbz_pend_r  <= 1'b0;
      a_raw_r     <= {WIDTH{1'b0}};
      opnd_r      <= {WIDTH{1'b0}};
      work_hi_r   <= {WIDTH{1'b0}};
      work_lo_r   <= {WIDTH{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= {WIDTH{1'b0}};
      lo          <= {WIDTH{1'b0}};
      div_by_zero <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_main_r  <= 1'b0;
      neg_rem_r   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            is_div_r    <= op[1];
            dbz_pend_r  <= op[1] & (b == {WIDTH{1'b0}});
            a_raw_r     <= a;
            work_hi_r   <= {WIDTH{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            div_by_zero <= 1'b0;
            busy        <= 1'b1;
            state_r     <= ST_RUN;
            if (op[1]) begin
              work_lo_r <= mag_a_s;
              opnd_r    <= mag_b_s;
            end else begin
              work_lo_r <= mag_b_s;
              opnd_r    <= mag_a_s;
            end
`ifdef MULDIV_SIGNED_EN
            neg_main_r <= sign_a_s ^ sign_b_s;
            neg_rem_r  <= sign_a_s;
`endif
          end else begin
            busy <= 1'b0;
          end
        end
        ST_RUN: begin
          work_hi_r <= next_hi_s;
          work_lo_r <= next_lo_s;
          cnt_r     <= cnt_r + CNT_W'(1);
          if (cnt_r == LAST_CNT) begin
            state_r <= ST_FIN;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_FIN: begin
          hi          <= res_hi_s;
          lo          <= res_lo_s;
          div_by_zero <= dbz_pend_r;
          done        <= 1'b1;
          busy        <= 1'b0;
          state_r     <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed and randomized checks of mul_div_unit against
// an arithmetic reference model (native *, /, % on plain integers).
module tb_mul_div_unit;

`ifdef MULDIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] hi;
  logic [15:0] lo;
  logic        div_by_zero;

  int tests = 0;
  int fails = 0;
  logic [31:0] prev_exp = 32'h0;

  mul_div_unit #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference result {hi, lo} from plain integer arithmetic.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
    bit sgn;
    int sx, sy, q, r;
    logic [31:0] p;
    sgn = SIGNED_EN && o[0];
    sx = sgn ? int'($signed(x)) : int'(x);
    sy = sgn ? int'($signed(y)) : int'(y);
    if (!o[1]) begin
      p = 32'(sx * sy);
      return p;
    end
    if (y == 16'h0) return {x, 16'hFFFF};
    q = sx / sy;
    r = sx % sy;
    return {r[15:0], q[15:0]};
  endfunction

  // Starts an op at the current negedge; returns at the negedge where done must be high.
  task automatic do_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                       input bit poke, input string tag);
    logic [31:0] exp;
    int n;
    exp = model(o, x, y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = 16'($urandom); b = 16'($urandom); op = 2'($urandom);
    check({tag, "_busy1"}, {31'h0, busy}, 32'h1);
    check({tag, "_done_low"}, {31'h0, done}, 32'h0);
    check({tag, "_dbz_clr"}, {31'h0, div_by_zero}, 32'h0);
    check({tag, "_hold"}, {hi, lo}, prev_exp);
    n = 1;
    for (int c = 2; c <= 40; c++) begin
      if (poke && c == 6) begin
        start = 1'b1; a = 16'($urandom); b = 16'($urandom); op = 2'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (busy) n++;
      else break;
    end
    start = 1'b0;
    check({tag, "_busy_len"}, 32'(n), 32'd17);
    check({tag, "_done"}, {31'h0, done}, 32'h1);
    check({tag, "_hilo"}, {hi, lo}, exp);
    check({tag, "_dbz"}, {31'h0, div_by_zero}, {31'h0, (o[1] && y == 16'h0)});
    prev_exp = exp;
  endtask

  initial begin
    int dseen;
    logic [1:0]  ro;
    logic [15:0] rx, ry;
    rst = 1'b1; start = 1'b0; op = 2'b00; a = 16'h0; b = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_hilo", {hi, lo}, 32'h0);
    check("rst_dbz", {31'h0, div_by_zero}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Reset in the middle of RUN: no result and no done pulse may follow.
    start = 1'b1; op = 2'b00; a = 16'h1234; b = 16'h0010;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_done", {31'h0, done}, 32'h0);
    check("midrst_hilo", {hi, lo}, 32'h0);
    dseen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) dseen++;
    end
    check("midrst_no_done", 32'(dseen), 32'd0);
    check("midrst_hilo_after", {hi, lo}, 32'h0);

    // Directed cases from the operation table.
    do_op(2'b00, 16'hFFFF, 16'hFFFF, 1'b0, "multu_ffff");
    @(negedge clk);
    check("done_one_cycle", {31'h0, done}, 32'h0);
    do_op(2'b01, 16'hFFFF, 16'hFFFF, 1'b0, "mult_ffff");
    @(negedge clk);
    do_op(2'b11, 16'hFFF9, 16'h0002, 1'b0, "div_m7_2");
    @(negedge clk);
    do_op(2'b10, 16'd100, 16'd7, 1'b0, "divu_100_7");
    @(negedge clk);
    do_op(2'b11, 16'h8000, 16'hFFFF, 1'b0, "div_minneg");
    @(negedge clk);
    do_op(2'b10, 16'h00AB, 16'h0000, 1'b0, "divu_zero");
    @(negedge clk);
    check("dbz_held", {31'h0, div_by_zero}, 32'h1);
    check("dbz_hilo_held", {hi, lo}, 32'h00AB_FFFF);
    do_op(2'b00, 16'h0003, 16'h0005, 1'b0, "multu_after_dbz");

    // Start poked while busy, then a back-to-back start in the done cycle.
    @(negedge clk);
    do_op(2'b00, 16'h1234, 16'h0010, 1'b1, "busy_poke");
    do_op(2'b10, 16'h7531, 16'h0123, 1'b0, "back2back");
    do_op(2'b11, 16'h0000, 16'h0000, 1'b1, "b2b_div_zero");

    // Randomized operations, some of them back-to-back.
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom);
      rx = 16'($urandom);
      ry = 16'($urandom);
      case ($urandom_range(0, 5))
        0: ry = 16'h0000;
        1: ry = 16'hFFFF;
        2: rx = 16'h8000;
        default: ;
      endcase
      do_op(ro, rx, ry, ($urandom_range(0, 3) == 0), "rand");
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide unit directly downstream of the register file; consumes its two read-data outputs as operands a and b.
- Produces a 2×WIDTH result as hi/lo registers, which the datapath reads back through the write-back mux.
- Iterative engine: one shift-add or restoring-subtract step per cycle. Control uses a start/busy/done handshake so the main controller can stall.

Parameters:
- WIDTH, 16, operand width in bits; must be even and at least 4. The iteration counter is sized to count WIDTH steps.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE.
- op  input  2  operation select: 00 MULTU, 01 MULT (signed), 10 DIVU, 11 DIV (signed).
- a  input  WIDTH  operand A (multiplicand or dividend), from register-file read_data1.
- b  input  WIDTH  operand B (multiplier or divisor), from register-file read_data2.
- busy  output  1  high while state is not IDLE.
- done  output  1  one-cycle pulse when hi/lo are updated.
- hi  output  WIDTH  multiply: upper product half; divide: remainder.
- lo  output  WIDTH  multiply: lower product half; divide: quotient.
- div_by_zero  output  1  set with done when a divide had b==0; held until the next accepted start.

Behaviour:
- Reset (rst=1 at an edge, from any state, including mid-operation):
  - state goes to IDLE; counter and working registers are cleared.
  - busy=0, done=0, hi=0, lo=0, div_by_zero=0.
  - No partial result is ever written to hi/lo.
- States: IDLE → RUN → FIN → IDLE.
  - IDLE: start=1 at an edge accepts the operation. a, b and op are latched; signed ops latch operand magnitudes plus sign bits. Counter is set to 0, div_by_zero is cleared, and state goes to RUN.
  - RUN: one iteration per edge. After WIDTH edges, state goes to FIN.
  - FIN: one edge applies sign correction, registers hi/lo, sets done=1, and returns to IDLE.
- Latency: start sampled at edge 0; busy is high for cycles 1..WIDTH+1; done is high in cycle WIDTH+2 only (18 for WIDTH=16).
- start while busy is ignored with no side effects. Operand changes after acceptance are ignored.
- start in the same cycle as done is accepted (back-to-back; done drops next cycle). Throughput is one operation per WIDTH+2 cycles.
- hi/lo hold their value from FIN until the next FIN or reset.
- Multiply: shift-add over WIDTH steps giving the full 2×WIDTH product, modulo 2^(2·WIDTH). MULT negates the magnitude product when sign(a) xor sign(b).
- Divide: restoring division over WIDTH steps. DIV sign rules:
  - quotient is negated when sign(a) xor sign(b).
  - remainder takes the sign of a (truncation toward zero).
  - Most-negative ÷ −1 wraps: lo=0x8000, hi=0.
- Divide by zero (b==0, either divide op): full latency is still taken; lo={WIDTH{1}}, hi=a as latched (raw bits), div_by_zero=1.
- Multiply ops always give div_by_zero=0.

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- Defined: op 01 and op 11 are signed as described above.
- Undefined: op[0] is ignored and every op runs unsigned (01 behaves as 00, 11 as 10). The sign-capture and negation logic is not synthesised. Latency is unchanged.

Test Plan:
- Reset mid-RUN: start MULTU a=0x1234 b=0x0010, assert rst at cycle 5 → next cycle busy=0, done=0, hi=lo=0; no done pulse follows.
- MULTU 0xFFFF×0xFFFF → done in cycle 18 after the start edge with hi=0xFFFE, lo=0x0001; busy high for exactly 17 cycles.
- MULT 0xFFFF×0xFFFF with MULDIV_SIGNED_EN → hi=0x0000, lo=0x0001. Same test without the macro → hi=0xFFFE, lo=0x0001.
- DIV 0xFFF9 (−7) ÷ 0x0002 → lo=0xFFFD (−3), hi=0xFFFF (−1). DIVU 100÷7 → lo=14, hi=2. DIV 0x8000 ÷ 0xFFFF → lo=0x8000, hi=0.
- DIVU 0x00AB ÷ 0 → after 18 cycles done=1, div_by_zero=1, lo=0xFFFF, hi=0x00AB. A following MULTU start clears div_by_zero at acceptance.
- Back-to-back with busy-start: pulse start again while busy (ignored, result unchanged); assert start with new operands in the done cycle → accepted, second done exactly 18 cycles later.
